// File: rtl/load_store_ctrl_if.sv
// Signal bundle between the ALU stage, the data-memory bus and load_store_ctrl.
// The controller uses the master view; the pipeline/memory environment uses the slave view.
interface load_store_ctrl_if #(
  parameter int cXLEN     = 32,
  parameter int cRegAddrW = 5
);
  logic                 iValid;
  logic                 oReady;
  logic                 iRead;
  logic                 iWrite;
  logic [2:0]           iOpType;
  logic [cXLEN-1:0]     iAddr;
  logic [cXLEN-1:0]     iWrData;
  logic [cRegAddrW-1:0] iRdAddr;
  logic                 oStall;
  logic                 oDmemReq;
  logic                 iDmemGnt;
  logic                 oDmemWe;
  logic [cXLEN-1:0]     oDmemAddr;
  logic [3:0]           oDmemBe;
  logic [cXLEN-1:0]     oDmemWdata;
  logic                 iDmemRvalid;
  logic [cXLEN-1:0]     iDmemRdata;
  logic                 oWbDv;
  logic [cRegAddrW-1:0] oWbAddr;
  logic [cXLEN-1:0]     oWbData;
  logic                 oExc;
  logic [cXLEN-1:0]     oExcAddr;
  logic                 oBusErr;

  modport master (
    input  iValid, iRead, iWrite, iOpType, iAddr, iWrData, iRdAddr,
    input  iDmemGnt, iDmemRvalid, iDmemRdata,
    output oReady, oStall, oDmemReq, oDmemWe, oDmemAddr, oDmemBe, oDmemWdata,
    output oWbDv, oWbAddr, oWbData, oExc, oExcAddr, oBusErr
  );

  modport slave (
    output iValid, iRead, iWrite, iOpType, iAddr, iWrData, iRdAddr,
    output iDmemGnt, iDmemRvalid, iDmemRdata,
    input  oReady, oStall, oDmemReq, oDmemWe, oDmemAddr, oDmemBe, oDmemWdata,
    input  oWbDv, oWbAddr, oWbData, oExc, oExcAddr, oBusErr
  );
endinterface

// File: rtl/load_store_ctrl.sv
// Load/store sequencer: legality check, single-port data-memory access with timeout,
// and aligned, sign/zero-extended load writeback.
module load_store_ctrl #(
  parameter int cXLEN     = 32,
  parameter int cRegAddrW = 5,
  parameter int cTimeout  = 255
) (
  input  logic              iClk,
  input  logic              iRst,
  load_store_ctrl_if.master bus
);
  localparam int               cCntW    = $clog2(cTimeout + 1);
  localparam logic [cCntW-1:0] cCntLast = cCntW'(cTimeout - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} stateT;

  stateT                state, stateNext;
  logic [cCntW-1:0]     cnt;
  logic [2:0]           opQ;
  logic [1:0]           offQ;
  logic [cRegAddrW-1:0] rdQ;
  logic                 weQ;
  logic [cXLEN-1:0]     addrQ, wdataQ;
  logic [3:0]           beQ;
  logic                 wbDvQ, excQ, busErrQ;
  logic [cRegAddrW-1:0] wbAddrQ;
  logic [cXLEN-1:0]     wbDataQ, excAddrQ;

  logic                 accept, legal, timeoutHit;
  logic [3:0]           beNext;
  logic [cXLEN-1:0]     wdataNext, rdShift, ldData;

  assign accept = bus.iValid && (state == IDLE);

  // Abort when the final allowed cycle in REQ/WAIT_RD passes without progress.
  assign timeoutHit = (cnt == cCntLast) &&
                      (((state == REQ) && !bus.iDmemGnt) ||
                       ((state == WAIT_RD) && !bus.iDmemRvalid));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    legal = 1'b0;
    case (bus.iOpType)
      3'b000:  legal = 1'b1;
      3'b001:  legal = !bus.iAddr[0];
      3'b010:  legal = (bus.iAddr[1:0] == 2'b00);
      3'b100:  legal = bus.iRead;
      3'b101:  legal = bus.iRead && !bus.iAddr[0];
      default: legal = 1'b0;
    endcase
    legal = legal && (bus.iRead ^ bus.iWrite);
  end

  always_comb begin
    beNext    = 4'b1111;
    wdataNext = bus.iWrData;
    case (bus.iOpType[1:0])
      2'b00: begin
        beNext    = 4'b0001 << bus.iAddr[1:0];
        wdataNext = {(cXLEN/8){bus.iWrData[7:0]}};
      end
      2'b01: begin
        beNext    = 4'b0011 << bus.iAddr[1:0];
        wdataNext = {(cXLEN/16){bus.iWrData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdShift = bus.iDmemRdata >> {offQ, 3'b000};
    ldData  = rdShift;
    case (opQ)
      3'b000:  ldData = {{(cXLEN-8){rdShift[7]}}, rdShift[7:0]};
      3'b001:  ldData = {{(cXLEN-16){rdShift[15]}}, rdShift[15:0]};
      3'b100:  ldData = {{(cXLEN-8){1'b0}}, rdShift[7:0]};
      3'b101:  ldData = {{(cXLEN-16){1'b0}}, rdShift[15:0]};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && legal) stateNext = REQ;
      REQ:     if (bus.iDmemGnt)    stateNext = weQ ? IDLE : WAIT_RD;
               else if (timeoutHit) stateNext = IDLE;
      WAIT_RD: if (bus.iDmemRvalid || timeoutHit) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.oReady     = (state == IDLE);
    bus.oStall     = (state != IDLE);
    bus.oDmemReq   = (state == REQ);
    bus.oDmemWe    = (state == REQ) && weQ;
    bus.oDmemAddr  = (state == REQ) ? addrQ  : '0;
    bus.oDmemBe    = (state == REQ) ? beQ    : '0;
    bus.oDmemWdata = (state == REQ) ? wdataQ : '0;
    bus.oWbDv      = wbDvQ;
    bus.oWbAddr    = wbAddrQ;
    bus.oWbData    = wbDataQ;
    bus.oExc       = excQ;
    bus.oExcAddr   = excAddrQ;
    bus.oBusErr    = busErrQ;
  end

  // Counter restarts on every state change, so it measures time spent in the current state.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                   cnt <= '0;
    else if (stateNext != state) cnt <= '0;
    else if (state != IDLE)      cnt <= cnt + cCntW'(1);
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      opQ      <= '0;
      offQ     <= '0;
      rdQ      <= '0;
      weQ      <= 1'b0;
      addrQ    <= '0;
      wdataQ   <= '0;
      beQ      <= '0;
      wbDvQ    <= 1'b0;
      wbAddrQ  <= '0;
      wbDataQ  <= '0;
      excQ     <= 1'b0;
      excAddrQ <= '0;
      busErrQ  <= 1'b0;
    end else begin
      wbDvQ   <= 1'b0;
      excQ    <= accept && (bus.iRead || bus.iWrite) && !legal;
      busErrQ <= timeoutHit;
      if (accept && (bus.iRead || bus.iWrite) && !legal) excAddrQ <= bus.iAddr;
      if (accept && legal) begin
        opQ    <= bus.iOpType;
        offQ   <= bus.iAddr[1:0];
        rdQ    <= bus.iRdAddr;
        weQ    <= bus.iWrite;
        addrQ  <= {bus.iAddr[cXLEN-1:2], 2'b00};
        wdataQ <= wdataNext;
        beQ    <= beNext;
      end
      if ((state == WAIT_RD) && bus.iDmemRvalid && (rdQ != '0)) begin
        wbDvQ   <= 1'b1;
        wbAddrQ <= rdQ;
        wbDataQ <= ldData;
      end
    end
  end
endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized ops checked against an arithmetic reference model.
module tb_load_store_ctrl;
  localparam int cXLEN     = 32;
  localparam int cRegAddrW = 5;
  localparam int cTimeout  = 8;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  load_store_ctrl_if #(.cXLEN(cXLEN), .cRegAddrW(cRegAddrW)) bus ();

  load_store_ctrl #(.cXLEN(cXLEN), .cRegAddrW(cRegAddrW), .cTimeout(cTimeout)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus.master)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rdAddr;
    logic [31:0] rdata;
    int          gntDly;
    int          rvDly;
  } opT;

  typedef enum {kIgnore, kExc, kStore, kLoad} kindT;

  typedef struct {
    kindT        kind;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wbData;
    logic        busErr;
  } expT;

  typedef struct {
    opT  op;
    expT exp;
  } vecT;

  vecT vecs[$];
  int  nChk = 0;
  int  nErr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  function automatic opT mkOp(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [4:0] rdAddr, logic [31:0] rdata,
                              int gntDly, int rvDly);
    opT o;
    o.rd = rd; o.wr = wr; o.f3 = f3; o.addr = addr; o.wdata = wdata;
    o.rdAddr = rdAddr; o.rdata = rdata; o.gntDly = gntDly; o.rvDly = rvDly;
    return o;
  endfunction

  function automatic expT mkExp(kindT kind, logic [3:0] be, logic [31:0] wdata,
                                logic [31:0] wbData, logic busErr);
    expT e;
    e.kind = kind; e.be = be; e.wdata = wdata; e.wbData = wbData; e.busErr = busErr;
    return e;
  endfunction

  task automatic addVec(input opT o, input expT e);
    vecT v;
    v.op  = o;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Reference model: access size in bytes, lane offset and arithmetic extension.
  function automatic expT model(opT op);
    expT         e;
    int          nBytes, off, beInt;
    logic [31:0] mask, rep, raw, v;
    bit          legalCode;
    e = mkExp(kIgnore, 4'h0, 32'h0, 32'h0, 1'b0);
    off    = int'(op.addr[1:0]);
    nBytes = 1 << int'(op.f3[1:0]);
    if (!op.rd && !op.wr) return e;
    legalCode = op.rd ? (int'(op.f3) inside {0, 1, 2, 4, 5}) : (int'(op.f3) inside {0, 1, 2});
    if ((op.rd && op.wr) || !legalCode || (off % nBytes) != 0) begin
      e.kind = kExc;
      return e;
    end
    e.kind = op.wr ? kStore : kLoad;
    beInt  = ((1 << nBytes) - 1) << off;
    e.be   = beInt[3:0];
    mask   = 32'((64'd1 << (8 * nBytes)) - 64'd1);
    rep    = (nBytes == 1) ? 32'h01010101 : (nBytes == 2) ? 32'h00010001 : 32'h1;
    e.wdata = (op.wdata & mask) * rep;
    raw = op.rdata >> (8 * off);
    v   = raw & mask;
    if (!op.f3[2] && nBytes < 4 && v >= 32'(64'd1 << (8 * nBytes - 1)))
      v = v - 32'(64'd1 << (8 * nBytes));
    e.wbData = v;
    e.busErr = (op.gntDly >= cTimeout) || (e.kind == kLoad && op.rvDly >= cTimeout);
    return e;
  endfunction

  task automatic idleInputs();
    bus.iValid = 1'b0; bus.iRead = 1'b0; bus.iWrite = 1'b0; bus.iOpType = 3'b0;
    bus.iAddr = 32'h0; bus.iWrData = 32'h0; bus.iRdAddr = 5'h0;
    bus.iDmemGnt = 1'b0; bus.iDmemRvalid = 1'b0; bus.iDmemRdata = 32'h0;
  endtask

  // Starts in a cycle where the controller is idle and ends in one as well.
  task automatic runOp(input opT op, input expT e, input string tag);
    bit wantWb;
    bit done;
    check({tag, " ready at issue"}, 32'(bus.oReady), 32'd1);
    bus.iValid = 1'b1; bus.iRead = op.rd; bus.iWrite = op.wr; bus.iOpType = op.f3;
    bus.iAddr = op.addr; bus.iWrData = op.wdata; bus.iRdAddr = op.rdAddr;
    step();
    bus.iValid = 1'b0; bus.iRead = 1'b0; bus.iWrite = 1'b0;
    bus.iAddr = $urandom; bus.iWrData = $urandom; bus.iRdAddr = 5'($urandom);
    done = 1'b0;
    if (e.kind == kStore || e.kind == kLoad) begin
      for (int c = 0; c < cTimeout && !done; c++) begin
        check({tag, " req"},   32'(bus.oDmemReq), 32'd1);
        check({tag, " stall"}, 32'(bus.oStall),   32'd1);
        check({tag, " addr"},  bus.oDmemAddr,     {op.addr[31:2], 2'b00});
        check({tag, " be"},    32'(bus.oDmemBe),  32'(e.be));
        check({tag, " we"},    32'(bus.oDmemWe),  32'(op.wr));
        if (op.wr) check({tag, " wdata"}, bus.oDmemWdata, e.wdata);
        done = (c == op.gntDly);
        bus.iDmemGnt = done;
        step();
        bus.iDmemGnt = 1'b0;
      end
      if (done && e.kind == kLoad) begin
        done = 1'b0;
        for (int c = 0; c < cTimeout && !done; c++) begin
          check({tag, " wait stall"}, 32'(bus.oStall),   32'd1);
          check({tag, " wait req"},   32'(bus.oDmemReq), 32'd0);
          done = (c == op.rvDly);
          bus.iDmemRvalid = done;
          bus.iDmemRdata  = done ? op.rdata : $urandom;
          step();
          bus.iDmemRvalid = 1'b0;
        end
      end
    end
    wantWb = (e.kind == kLoad) && !e.busErr && (op.rdAddr != 5'd0);
    check({tag, " done ready"}, 32'(bus.oReady),   32'd1);
    check({tag, " done req"},   32'(bus.oDmemReq), 32'd0);
    check({tag, " busErr"},     32'(bus.oBusErr),  32'(e.busErr));
    check({tag, " exc"},        32'(bus.oExc),     32'(e.kind == kExc));
    check({tag, " wbDv"},       32'(bus.oWbDv),    32'(wantWb));
    if (e.kind == kExc) check({tag, " excAddr"}, bus.oExcAddr, op.addr);
    if (wantWb) begin
      check({tag, " wbAddr"}, 32'(bus.oWbAddr), 32'(op.rdAddr));
      check({tag, " wbData"}, bus.oWbData,      e.wbData);
    end
    step();
    check({tag, " pulses low"}, {29'd0, bus.oWbDv, bus.oExc, bus.oBusErr}, 32'd0);
  endtask

  initial begin
    opT  op;
    expT e;

    // lw/lb/lbu/sh/misaligned/illegal/timeout corners with hand-derived expectations.
    addVec(mkOp(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0),
           mkExp(kLoad, 4'b1111, 32'h0, 32'hDEADBEEF, 0));
    addVec(mkOp(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF0000, 0, 0),
           mkExp(kLoad, 4'b1000, 32'h0, 32'hFFFFFF80, 0));
    addVec(mkOp(1, 0, 3'b100, 32'h103, 32'h0, 5'd8, 32'h80FF0000, 0, 0),
           mkExp(kLoad, 4'b1000, 32'h0, 32'h00000080, 0));
    addVec(mkOp(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 32'h0, 3, 0),
           mkExp(kStore, 4'b1100, 32'hABCDABCD, 32'h0, 0));
    addVec(mkOp(1, 0, 3'b010, 32'h101, 32'h0, 5'd3, 32'h0, 0, 0),
           mkExp(kExc, 4'b0000, 32'h0, 32'h0, 0));
    addVec(mkOp(0, 1, 3'b011, 32'h300, 32'h55, 5'd0, 32'h0, 0, 0),
           mkExp(kExc, 4'b0000, 32'h0, 32'h0, 0));
    addVec(mkOp(1, 0, 3'b001, 32'h102, 32'h0, 5'd9, 32'h80017777, 1, 1),
           mkExp(kLoad, 4'b1100, 32'h0, 32'hFFFF8001, 0));
    addVec(mkOp(1, 0, 3'b101, 32'h106, 32'h0, 5'd10, 32'hFFFF1234, 0, 2),
           mkExp(kLoad, 4'b1100, 32'h0, 32'h0000FFFF, 0));
    addVec(mkOp(0, 1, 3'b000, 32'h011, 32'h123456A5, 5'd0, 32'h0, 0, 0),
           mkExp(kStore, 4'b0010, 32'hA5A5A5A5, 32'h0, 0));
    addVec(mkOp(0, 1, 3'b010, 32'h040, 32'hCAFEF00D, 5'd0, 32'h0, 1, 0),
           mkExp(kStore, 4'b1111, 32'hCAFEF00D, 32'h0, 0));
    addVec(mkOp(1, 0, 3'b010, 32'h044, 32'h0, 5'd0, 32'h11111111, 0, 2),
           mkExp(kLoad, 4'b1111, 32'h0, 32'h11111111, 0));
    addVec(mkOp(1, 0, 3'b001, 32'h101, 32'h0, 5'd2, 32'h0, 0, 0),
           mkExp(kExc, 4'b0000, 32'h0, 32'h0, 0));
    addVec(mkOp(1, 1, 3'b010, 32'h080, 32'h0, 5'd2, 32'h0, 0, 0),
           mkExp(kExc, 4'b0000, 32'h0, 32'h0, 0));
    addVec(mkOp(0, 0, 3'b010, 32'h084, 32'h0, 5'd2, 32'h0, 0, 0),
           mkExp(kIgnore, 4'b0000, 32'h0, 32'h0, 0));
    addVec(mkOp(0, 1, 3'b101, 32'h020, 32'h0, 5'd0, 32'h0, 0, 0),
           mkExp(kExc, 4'b0000, 32'h0, 32'h0, 0));
    addVec(mkOp(1, 0, 3'b000, 32'h001, 32'h0, 5'd1, 32'h00007F00, 2, 1),
           mkExp(kLoad, 4'b0010, 32'h0, 32'h0000007F, 0));
    addVec(mkOp(0, 1, 3'b010, 32'h090, 32'h600DF00D, 5'd0, 32'h0, 99, 0),
           mkExp(kStore, 4'b1111, 32'h600DF00D, 32'h0, 1));
    addVec(mkOp(1, 0, 3'b010, 32'h088, 32'h0, 5'd4, 32'h0, 0, 99),
           mkExp(kLoad, 4'b1111, 32'h0, 32'h0, 1));

    idleInputs();
    iRst = 1'b0;
    step();
    step();
    check("reset ready",  32'(bus.oReady),   32'd1);
    check("reset stall",  32'(bus.oStall),   32'd0);
    check("reset req",    32'(bus.oDmemReq), 32'd0);
    check("reset be",     32'(bus.oDmemBe),  32'd0);
    check("reset pulses", {29'd0, bus.oWbDv, bus.oExc, bus.oBusErr}, 32'd0);
    check("reset wbData", bus.oWbData,       32'd0);
    iRst = 1'b1;
    step();

    foreach (vecs[i]) runOp(vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));

    // The last vector timed out in WAIT_RD: a late rvalid must not write back.
    bus.iDmemRvalid = 1'b1;
    bus.iDmemRdata  = 32'h0BADBEEF;
    step();
    bus.iDmemRvalid = 1'b0;
    check("late rvalid wbDv", 32'(bus.oWbDv), 32'd0);
    check("late rvalid ready", 32'(bus.oReady), 32'd1);

    // Reset asserted while waiting for read data drops the access.
    bus.iValid = 1'b1; bus.iRead = 1'b1; bus.iOpType = 3'b010;
    bus.iAddr = 32'h200; bus.iRdAddr = 5'd3;
    step();
    bus.iValid = 1'b0; bus.iRead = 1'b0;
    bus.iDmemGnt = 1'b1;
    step();
    bus.iDmemGnt = 1'b0;
    check("pre-reset stall", 32'(bus.oStall), 32'd1);
    #2 iRst = 1'b0;
    #1;
    check("midreset ready", 32'(bus.oReady),   32'd1);
    check("midreset stall", 32'(bus.oStall),   32'd0);
    check("midreset req",   32'(bus.oDmemReq), 32'd0);
    step();
    iRst = 1'b1;
    bus.iDmemRvalid = 1'b1;
    bus.iDmemRdata  = 32'h12345678;
    step();
    bus.iDmemRvalid = 1'b0;
    check("post-reset rvalid wbDv", 32'(bus.oWbDv), 32'd0);
    runOp(vecs[0].op, vecs[0].exp, "after reset");

    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      op.rd = (sel <= 4) || (sel == 8);
      op.wr = (sel >= 5 && sel <= 8);
      if (sel == 9) begin op.rd = 1'b0; op.wr = 1'b0; end
      op.f3     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (op.rd && !op.wr && $urandom_range(0, 2) == 0) op.f3[2] = 1'b1;
      op.addr   = $urandom;
      op.wdata  = $urandom;
      op.rdata  = $urandom;
      op.rdAddr = 5'($urandom);
      op.gntDly = ($urandom_range(0, 15) == 0) ? cTimeout : $urandom_range(0, 3);
      op.rvDly  = ($urandom_range(0, 15) == 0) ? cTimeout : $urandom_range(0, 3);
      e = model(op);
      runOp(op, e, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule

// File: doc/load_store_ctrl.md
Name: load_store_ctrl

Overview:
Sequences the ALU memory-op result (load/store address, store data, funct3 size code, rd address) onto the single-port data-memory bus and returns aligned, sign/zero-extended load data to the register writeback path. It holds the pipeline stalled while an access is outstanding. It detects misaligned or illegal accesses before issuing them and aborts hung bus transactions with a timeout.

Parameters:
cXLEN, 32, data/address width
cRegAddrW, 5, register address width
cTimeout, 255, max cycles spent in REQ or WAIT_RD before abort (counter width = $clog2(cTimeout+1))

Ports:
iClk  in  1  clock
iRst  in  1  reset, asynchronous, active-low
iValid  in  1  memory op presented by ALU stage
oReady  out  1  op accepted when iValid & oReady
iRead  in  1  load request
iWrite  in  1  store request
iOpType  in  3  funct3 size code
iAddr  in  cXLEN  byte address
iWrData  in  cXLEN  store data (rs2)
iRdAddr  in  cRegAddrW  load destination
oStall  out  1  pipeline stall
oDmemReq  out  1  bus request
iDmemGnt  in  1  bus grant
oDmemWe  out  1  write enable
oDmemAddr  out  cXLEN  word-aligned address ({iAddr[cXLEN-1:2],2'b00})
oDmemBe  out  4  byte enables
oDmemWdata  out  cXLEN  lane-positioned write data
iDmemRvalid  in  1  read data valid
iDmemRdata  in  cXLEN  read word
oWbDv  out  1  writeback valid, 1-cycle pulse
oWbAddr  out  cRegAddrW  writeback register
oWbData  out  cXLEN  writeback data
oExc  out  1  misaligned/illegal pulse
oExcAddr  out  cXLEN  faulting byte address
oBusErr  out  1  timeout pulse

Behaviour:
- Reset: async on iRst=0; state IDLE, timeout counter 0, all outputs 0 except oReady=1 (combinational from IDLE). Reset mid-transaction drops the access; a later iDmemGnt/iDmemRvalid seen in IDLE is ignored.
- States: IDLE, REQ, WAIT_RD.
- oReady = (state==IDLE). oStall = (state!=IDLE).
- IDLE, accept (iValid & oReady) with exactly one of iRead/iWrite set: latch op fields. Then legality check:
  - Load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Store funct3: 000 sb, 001 sh, 010 sw.
  - Other codes, iRead&iWrite both set, half-word with addr[0]=1, or word with addr[1:0]!=0: illegal. Next cycle oExc=1 and oExcAddr=iAddr; no bus access; stay IDLE.
  - Accept with neither iRead nor iWrite: ignored.
- Legal op: next cycle state=REQ, oDmemReq=1. Address/We/Be/Wdata are registered and held stable until grant.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Write data: sb replicates byte[7:0] to all four lanes; sh replicates half[15:0] to both halves; sw passes the word through.
- REQ, iDmemGnt=1 (same cycle as req counts): oDmemReq drops next cycle.
  - Store: return to IDLE.
  - Load: go to WAIT_RD.
- WAIT_RD, iDmemRvalid=1: shift iDmemRdata right by 8*addr[1:0], then extend.
  - lb/lh: sign-extend from bit 7/15.
  - lbu/lhu: zero-extend.
  - lw: unchanged.
  - Next cycle oWbDv=1 with oWbAddr/oWbData; return to IDLE. If rd=0, oWbDv stays 0; the access still completes.
- Timeout: counter clears on entry to REQ and on entry to WAIT_RD, increments each cycle in those states. On reaching cTimeout: oBusErr=1 for one cycle, oDmemReq=0, state=IDLE.
- Latency, zero-wait bus, accept at T:
  - Req at T+1.
  - Store: oReady at T+2.
  - Load with rvalid at T+2: oWbDv at T+3, oReady at T+3.
- Pulses (oWbDv, oExc, oBusErr) are high for exactly one cycle and are mutually exclusive.

Test Plan:
- lw addr 0x100, gnt same cycle as req, rvalid next cycle with rdata 0xDEADBEEF, rd=5 -> oDmemAddr=0x100, Be=1111, oWbDv at T+3 with addr 5, data 0xDEADBEEF.
- lb addr 0x103 (rdata 0x80FF_0000) and lbu at the same address -> Be=1000 on the bus; lb writes back 0xFFFFFF80, lbu writes back 0x00000080.
- sh addr 0x202, data 0x1234ABCD, gnt held low 3 cycles -> req/addr/Be(1100)/Wdata(0xABCDABCD) stable all 4 cycles; oStall high throughout; oReady returns the cycle after gnt.
- lw addr 0x101 and store with funct3=011 -> oExc pulse with oExcAddr=0x101 (then the store's address), oDmemReq never asserted.
- Load granted, rvalid never arrives (cTimeout=8) -> oBusErr pulse 8 cycles after entering WAIT_RD, back to IDLE; a late rvalid produces no oWbDv.
- iRst low while in WAIT_RD -> outputs cleared immediately; subsequent rvalid ignored; next op completes normally.
